hs_cdc_tx_arbiter: RTL and testbench

Driver-side controller for the 4-phase req/ack CDC channel. It shares one crossing among N_REQ local requesters using round-robin arbitration. It latches the winner's data and source ID, sequences data_req against the synchronised data_ack, returns a per-source done pulse, and flags acks that never arrive.

---
 rtl/hs_cdc_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/hs_cdc_tx_arbiter.sv | 130 +++++++++++++
 tb/tb_hs_cdc_tx_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hs_cdc_pkg.sv
// Shared types and helpers for the req/ack CDC transmit side.
package hs_cdc_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_ID_W   = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        REQ,
        RELEASE
    } state_e;

    // Smallest r with 2**r >= value; 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin find-first over N_REQ requesters, searching upward from a
// registered pointer that moves past the winner when grant_adv_i strobes.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic              clk_driver,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req_i,
    input  logic              grant_adv_i,
    input  logic [ID_W-1:0]   adv_id_i,
    output logic              grant_vld_o,
    output logic [ID_W-1:0]   grant_id_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W:0]   pos;

    // Walk offsets from the far end so the nearest requester is written last.
    always_comb begin
        grant_vld_o = 1'b0;
        grant_id_o  = '0;
        pos         = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr_q} + (ID_W + 1)'(k);
            if (pos >= (ID_W + 1)'(N_REQ)) pos = pos - (ID_W + 1)'(N_REQ);
            if (req_i[pos[ID_W-1:0]]) begin
                grant_vld_o = 1'b1;
                grant_id_o  = pos[ID_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_adv_i) begin
            ptr_d = (adv_id_i == ID_W'(N_REQ - 1)) ? '0 : adv_id_i + ID_W'(1);
        end
    end

    always_ff @(posedge clk_driver or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/hs_cdc_tx_arbiter.sv
// Sender side of a 4-phase req/ack crossing shared round-robin between
// N_REQ local sources, with per-source completion pulses and an ack timeout.
module hs_cdc_tx_arbiter
    import hs_cdc_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ID_W    = DEF_ID_W,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk_driver,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          src_valid,
    input  logic [N_REQ*DATA_W-1:0]   src_data,
    output logic [N_REQ-1:0]          src_done,
    output logic                      data_req,
    output logic [DATA_W-1:0]         data_out,
    output logic [ID_W-1:0]           data_id,
    input  logic                      data_ack,
    output logic                      busy,
    output logic                      err_timeout,
    input  logic                      err_clr
);

    localparam int CNT_W = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e              state_q, state_d;
    logic                ack_meta_q, ack_s_q;
    logic                req_q, req_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                grant_adv;
    logic                grant_vld;
    logic [ID_W-1:0]     grant_id;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
        .clk_driver  (clk_driver),
        .rst_n       (rst_n),
        .req_i       (src_valid),
        .grant_adv_i (grant_adv),
        .adv_id_i    (id_q),
        .grant_vld_o (grant_vld),
        .grant_id_o  (grant_id)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        data_d    = data_q;
        id_d      = id_q;
        done_d    = '0;
        err_d     = err_clr ? 1'b0 : err_q;
        cnt_d     = cnt_q;
        grant_adv = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        if (grant_id == ID_W'(i)) data_d = src_data[i*DATA_W +: DATA_W];
                    end
                    id_d    = grant_id;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                req_d   = 1'b1;
                cnt_d   = '0;
                state_d = REQ;
            end
            REQ: begin
                // An ack landing on the last allowed cycle still counts as success.
                if (ack_s_q) begin
                    req_d     = 1'b0;
                    grant_adv = 1'b1;
                    state_d   = RELEASE;
                    for (int i = 0; i < N_REQ; i++) done_d[i] = (id_q == ID_W'(i));
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = RELEASE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (!ack_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the synchroniser flops are reset too, so no stale ack survives a reset.
    always_ff @(posedge clk_driver or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
            state_q    <= IDLE;
            req_q      <= 1'b0;
            data_q     <= '0;
            id_q       <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            ack_meta_q <= data_ack;
            ack_s_q    <= ack_meta_q;
            state_q    <= state_d;
            req_q      <= req_d;
            data_q     <= data_d;
            id_q       <= id_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign data_req    = req_q;
    assign data_out    = data_q;
    assign data_id     = id_q;
    assign src_done    = done_q;
    assign err_timeout = err_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_hs_cdc_tx_arbiter.sv
// Randomised bench for hs_cdc_tx_arbiter: a transaction-level model predicts
// winner, payload, request length, completion pulse and error flag per word.
module tb_hs_cdc_tx_arbiter;

    localparam int N     = 4;
    localparam int DW    = 4;
    localparam int IW    = 2;
    localparam int TO    = 8;
    localparam int NEVER = -1;

    logic              clk_driver = 1'b0;
    logic              rst_n      = 1'b1;
    logic [N-1:0]      src_valid  = '0;
    logic [N*DW-1:0]   src_data   = '0;
    logic [N-1:0]      src_done;
    logic              data_req;
    logic [DW-1:0]     data_out;
    logic [IW-1:0]     data_id;
    logic              data_ack   = 1'b0;
    logic              busy;
    logic              err_timeout;
    logic              err_clr    = 1'b0;

    hs_cdc_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .ID_W(IW), .TIMEOUT(TO)) dut (
        .clk_driver  (clk_driver),
        .rst_n       (rst_n),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_done    (src_done),
        .data_req    (data_req),
        .data_out    (data_out),
        .data_id     (data_id),
        .data_ack    (data_ack),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 clk_driver = ~clk_driver;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model state: one in-flight word at a time, scheduled at grant.
    int              cyc = 0;
    bit              active = 0;
    int              rise_cyc, fall_cyc, busy_low_cyc, d_sel, h_sel;
    bit              success;
    logic [IW-1:0]   exp_id, m_ptr = '0;
    logic [DW-1:0]   exp_data;
    bit              m_err = 0, clr_prev = 0;
    bit              rand_src = 0, rand_clr = 0, force_clr = 0, rr_data = 0;
    int              src_pct = 0;
    int              d_q[$];
    logic [N-1:0]    inj_mask = '0;
    logic [N*DW-1:0] inj_data = '0;

    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] v, input logic [IW-1:0] ptr);
        for (int k = 0; k < N; k++) begin
            int idx = (int'(ptr) + k) % N;
            if (v[idx]) return IW'(idx);
        end
        return ptr;
    endfunction

    function automatic int rand_d();
        int r = $urandom_range(0, 7);
        return (r <= 5) ? r : NEVER;
    endfunction

    task automatic step();
        logic [N-1:0] exp_done;
        @(negedge clk_driver);
        cyc++;
        exp_done = '0;
        if (active && cyc == fall_cyc && success) begin
            exp_done[exp_id] = 1'b1;
            m_ptr = IW'((int'(exp_id) + 1) % N);
        end
        if (active && cyc == fall_cyc && !success) m_err = 1;
        else if (clr_prev)                          m_err = 0;

        check("src_done", src_done, exp_done);
        check("err_timeout", err_timeout, m_err);
        if (!active) begin
            check("busy_idle", busy, 1'b0);
            check("req_idle", data_req, 1'b0);
        end else begin
            check("busy", busy, cyc < busy_low_cyc);
            check("data_req", data_req, cyc >= rise_cyc && cyc < fall_cyc);
            if (cyc >= rise_cyc && cyc < busy_low_cyc) begin
                check("data_out", data_out, exp_data);
                check("data_id", data_id, exp_id);
            end
            if (cyc == busy_low_cyc) active = 0;
        end

        // Receiver: ack d cycles after req is seen, drop it h cycles after req falls.
        data_ack = active && success && cyc >= rise_cyc + d_sel && cyc < fall_cyc + h_sel;
        for (int i = 0; i < N; i++) begin
            if (src_done[i]) begin
                src_valid[i] = 1'b0;
            end else if (inj_mask[i]) begin
                src_valid[i] = 1'b1;
                src_data[i*DW +: DW] = inj_data[i*DW +: DW];
            end else if (!src_valid[i] && rand_src && $urandom_range(0, 99) < src_pct) begin
                src_valid[i] = 1'b1;
                src_data[i*DW +: DW] = rr_data ? DW'(i + 1) : DW'($urandom);
            end
        end
        inj_mask  = '0;
        err_clr   = force_clr || (rand_clr && $urandom_range(0, 7) == 0);
        force_clr = 0;
        clr_prev  = err_clr;

        if (!active && src_valid != '0) begin
            exp_id       = rr_pick(src_valid, m_ptr);
            exp_data     = src_data[int'(exp_id)*DW +: DW];
            d_sel        = (d_q.size() > 0) ? d_q.pop_front() : rand_d();
            // Ack reaches the FSM 3 cycles after it is driven; REQ lasts at most TO cycles.
            success      = (d_sel != NEVER) && (d_sel + 3 <= TO);
            h_sel        = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3));
            rise_cyc     = cyc + 2;
            fall_cyc     = rise_cyc + (success ? d_sel + 3 : TO);
            busy_low_cyc = success ? fall_cyc + h_sel + 3 : fall_cyc + 1;
            active       = 1;
        end
    endtask

    task automatic run_until_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            step();
            if (!active && src_valid == '0) return;
        end
        check("drain", {30'd0, active, |src_valid}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},  data_req, 1'b0);
        check({tag, "_out"},  data_out, '0);
        check({tag, "_id"},   data_id, '0);
        check({tag, "_done"}, src_done, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_err"},  err_timeout, 1'b0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(negedge clk_driver);
        rst_n = 1'b1;

        // Single source, ack 3 cycles after req.
        inj_mask = 4'b0001;
        inj_data = {12'h000, 4'hA};
        d_q.push_back(3);
        step();
        run_until_idle(80);

        // All four sources continuously valid with data 1..4.
        rr_data  = 1;
        rand_src = 1;
        src_pct  = 100;
        inj_mask = 4'b1111;
        inj_data = {4'h4, 4'h3, 4'h2, 4'h1};
        repeat (80) step();
        rand_src = 0;
        run_until_idle(200);
        rr_data  = 0;

        // Ack never arrives, then the retry is acked on the last REQ cycle.
        inj_mask = 4'b0100;
        inj_data = {4'h0, 4'h9, 8'h00};
        d_q.push_back(NEVER);
        d_q.push_back(5);
        step();
        run_until_idle(100);
        force_clr = 1;
        repeat (2) step();

        // Random traffic with random clears and occasional slow releases.
        rand_src = 1;
        src_pct  = 10;
        rand_clr = 1;
        repeat (3000) step();
        rand_src = 0;
        run_until_idle(400);

        // Reset while a request is outstanding.
        rand_src = 1;
        src_pct  = 30;
        for (int i = 0; i < 200 && !data_req; i++) step();
        check("reach_req", data_req, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreq");
        active = 0; m_ptr = '0; m_err = 0; clr_prev = 0;
        rand_src = 0; rand_clr = 0; src_valid = '0; data_ack = 1'b0; err_clr = 1'b0;
        d_q.delete();
        @(negedge clk_driver);
        rst_n = 1'b1;

        // Pointer back at 0: all valid must grant 0,1,2,3 in order.
        rr_data  = 1;
        inj_mask = 4'b1111;
        inj_data = {4'h4, 4'h3, 4'h2, 4'h1};
        step();
        run_until_idle(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
